// File: rtl/fifo_rgb_pkg.sv
// rtl/fifo_rgb_pkg.sv - shared state type and byte-lane constants for the RGB unpacker
package fifo_rgb_pkg;

  typedef enum logic {
    WAIT_FILL = 1'b0,
    RUN       = 1'b1
  } state_e;

  localparam int LANE_R = 2;
  localparam int LANE_G = 1;
  localparam int LANE_B = 0;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_rgb_unpack.sv
// rtl/fifo_rgb_unpack.sv - pulls R,G,B bytes from a FIFO and presents 24-bit pixels
// Waits for a fill level, then streams pixels with a valid/ready handshake.
module fifo_rgb_unpack
  import fifo_rgb_pkg::*;
#(
  parameter int FILL_THRESH = 1536,
  parameter int WL_WIDTH    = 14
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  output logic                fifo_rd_en,
  input  logic [7:0]          fifo_rd_data,
  input  logic                fifo_rd_empty,
  input  logic [WL_WIDTH-1:0] fifo_rd_water_level,
  input  logic                frame_start,
  input  logic                pix_ready,
  output logic                pix_valid,
  output logic [23:0]         pix_data,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam logic [WL_WIDTH-1:0] THRESH = WL_WIDTH'(FILL_THRESH);

  state_e      state_q, state_d;
  logic [1:0]  held_q, held_d;
  logic        inflight_q, inflight_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic        pix_valid_q, pix_valid_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic        underrun_q, underrun_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        has_room;

  // A read is safe when the pending bytes cannot complete a pixel into an occupied output.
  always_comb begin
    has_room   = ((held_q + {1'b0, inflight_q}) < 2'd2) || !pix_valid_q || pix_ready;
    fifo_rd_en = (state_q == RUN) && !fifo_rd_empty && has_room;
  end

  always_comb begin
    state_d        = state_q;
    held_d         = held_q;
    inflight_d     = fifo_rd_en;
    r_d            = r_q;
    g_d            = g_q;
    pix_valid_d    = pix_valid_q;
    pix_data_d     = pix_data_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;

    case (state_q)
      WAIT_FILL: begin
        if (fifo_rd_water_level >= THRESH) state_d = RUN;
      end
      RUN: begin
        if (pix_ready && !pix_valid_q) begin
          underrun_d = 1'b1;
          if (underrun_cnt_q != UNDERRUN_MAX) underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
      default: state_d = WAIT_FILL;
    endcase

    if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;

    if (inflight_q) begin
      case (held_q)
        2'd0: begin
          r_d    = fifo_rd_data;
          held_d = 2'd1;
        end
        2'd1: begin
          g_d    = fifo_rd_data;
          held_d = 2'd2;
        end
        default: begin
          pix_data_d[8*LANE_R +: 8] = r_q;
          pix_data_d[8*LANE_G +: 8] = g_q;
          pix_data_d[8*LANE_B +: 8] = fifo_rd_data;
          pix_valid_d               = 1'b1;
          held_d                    = 2'd0;
        end
      endcase
    end

    // Resync drops everything partial, including a pixel completing this very cycle.
    if (frame_start) begin
      state_d     = WAIT_FILL;
      held_d      = 2'd0;
      inflight_d  = 1'b0;
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q        <= WAIT_FILL;
      held_q         <= 2'd0;
      inflight_q     <= 1'b0;
      r_q            <= 8'd0;
      g_q            <= 8'd0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= 24'd0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      held_q         <= held_d;
      inflight_q     <= inflight_d;
      r_q            <= r_d;
      g_q            <= g_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_fifo_rgb_unpack.sv
// tb/tb_fifo_rgb_unpack.sv - randomized and directed bench with a byte-stream reference model
module tb_fifo_rgb_unpack;

  localparam int THRESH = 1536;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_empty;
  logic [13:0] fifo_rd_water_level;
  logic        frame_start;
  logic        pix_ready;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  part_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [7:0]  bytes_a[12];
  logic        run_m, arr_m, fs_prev, force_empty, rd_en_s;
  logic [7:0]  arr_byte;
  int unsigned ur_m;
  int          cyc, pops, first_rd, first_pv;

  fifo_rgb_unpack #(.FILL_THRESH(THRESH), .WL_WIDTH(14)) dut (
    .rd_clk              (rd_clk),
    .rd_rst_n            (rd_rst_n),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .frame_start         (frame_start),
    .pix_ready           (pix_ready),
    .pix_valid           (pix_valid),
    .pix_data            (pix_data),
    .underrun            (underrun),
    .underrun_cnt        (underrun_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: compare outputs against the byte-stream model at negedge, then advance the FIFO.
  task automatic tick();
    logic exp_en, exp_pv, next_run;
    fifo_rd_empty = force_empty || (fifo_q.size() == 0);
    @(negedge rd_clk);
    cyc++;
    rd_en_s = fifo_rd_en;
    exp_pv  = (exp_q.size() != 0);
    exp_en  = run_m && !fifo_rd_empty &&
              (((part_q.size() + int'(arr_m)) < 2) || !exp_pv || pix_ready);
    check("rd_en", fifo_rd_en, exp_en);
    check("pix_valid", pix_valid, exp_pv);
    if (exp_pv) check("pix_data", pix_data, exp_q[0]);
    check("underrun_cnt", underrun_cnt, ur_m);
    check("underrun", underrun, ur_m != 0);
    if (fifo_rd_en && first_rd < 0) first_rd = cyc;
    if (pix_valid && first_pv < 0) first_pv = cyc;
    if (pix_valid && pix_ready) got_q.push_back(pix_data);
    if (exp_pv && pix_ready) void'(exp_q.pop_front());
    if (run_m && pix_ready && !exp_pv && ur_m < 32'hFFFF) ur_m++;
    if (arr_m && !frame_start && !fs_prev) begin
      part_q.push_back(arr_byte);
      if (part_q.size() == 3) begin
        exp_q.push_back({part_q[0], part_q[1], part_q[2]});
        part_q.delete();
      end
    end
    if (frame_start) begin
      part_q.delete();
      exp_q.delete();
    end
    next_run = !frame_start && (run_m || (fifo_rd_water_level >= 14'(THRESH)));
    fs_prev  = frame_start;
    arr_m    = rd_en_s && (fifo_q.size() != 0);
    @(posedge rd_clk);
    #1;
    run_m = next_run;
    if (arr_m) begin
      arr_byte     = fifo_q.pop_front();
      fifo_rd_data = arr_byte;
      pops++;
    end else begin
      fifo_rd_data = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rd_rst_n            = 1'b0;
    frame_start         = 1'b0;
    pix_ready           = 1'b0;
    fifo_rd_water_level = 14'd0;
    force_empty         = 1'b0;
    fifo_q.delete();
    part_q.delete();
    exp_q.delete();
    got_q.delete();
    run_m = 1'b0; arr_m = 1'b0; fs_prev = 1'b0;
    ur_m = 0; pops = 0; first_rd = -1; first_pv = -1;
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_underrun_cnt"}, underrun_cnt, 0);
  endtask

  initial begin
    rd_rst_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b0; fifo_rd_data = 8'd0;
    fifo_rd_empty = 1'b1; fifo_rd_water_level = 14'd0; cyc = 0;
    #2;
    check_zero("reset");

    // Fill threshold boundary, then first pixels and latency.
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fifo_rd_water_level = 14'd0;
    tick();
    fifo_rd_water_level = 14'd1535;
    repeat (3) tick();
    check("rd_en_at_1535", rd_en_s, 0);
    fifo_rd_water_level = 14'd1536;
    pix_ready = 1'b1;
    tick();
    check("rd_en_at_1536", rd_en_s, 0);
    tick();
    check("rd_en_after_1536", rd_en_s, 1);
    repeat (12) tick();
    check("latency", first_pv - first_rd, 4);
    check("pix_count", got_q.size(), 2);
    check("pix0", (got_q.size() > 0) ? got_q[0] : 24'd0, 24'h112233);
    check("pix1", (got_q.size() > 1) ? got_q[1] : 24'd0, 24'h445566);

    // Backpressure: stall 20 cycles then drain in order.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bytes_a[i] = 8'($urandom);
      fifo_q.push_back(bytes_a[i]);
    end
    fifo_rd_water_level = 14'd1536;
    tick();
    repeat (20) tick();
    check("stall_pops", pops, 5);
    pix_ready = 1'b1;
    repeat (30) tick();
    check("drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("drain_pix", (got_q.size() > i) ? got_q[i] : 24'd0,
            {bytes_a[3*i], bytes_a[3*i+1], bytes_a[3*i+2]});

    // FIFO empties after one byte: ten underrun cycles.
    do_reset();
    fifo_q.push_back(8'h5A);
    fifo_rd_water_level = 14'd1536;
    pix_ready = 1'b1;
    tick();
    repeat (10) tick();
    check("ur_cnt_10", underrun_cnt, 10);
    check("ur_flag", underrun, 1);
    check("ur_pops", pops, 1);
    pix_ready = 1'b0;
    tick();

    // frame_start after two bytes of a pixel.
    do_reset();
    fifo_q = '{8'h01, 8'h02};
    fifo_rd_water_level = 14'd1536;
    tick();
    repeat (4) tick();
    frame_start = 1'b1;
    fifo_rd_water_level = 14'd0;
    tick();
    frame_start = 1'b0;
    tick();
    check("fs_pix_valid", pix_valid, 0);
    check("fs_wait_rd_en", fifo_rd_en, 0);
    fifo_q = '{8'hA1, 8'hB2, 8'hC3};
    fifo_rd_water_level = 14'd1536;
    pix_ready = 1'b1;
    repeat (10) tick();
    check("fs_new_count", got_q.size(), 1);
    check("fs_new_pix", (got_q.size() > 0) ? got_q[0] : 24'd0, 24'hA1B2C3);

    // Randomized traffic with occasional resync and empty glitches.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 24 && $urandom_range(0, 2) != 0) fifo_q.push_back(8'($urandom));
      pix_ready           = ($urandom_range(0, 3) != 0);
      frame_start         = ($urandom_range(0, 149) == 0);
      force_empty         = ($urandom_range(0, 15) == 0);
      fifo_rd_water_level = 14'($urandom_range(1500, 1570));
      tick();
    end
    frame_start = 1'b0;
    force_empty = 1'b0;

    // Saturating underrun counter.
    do_reset();
    fifo_rd_water_level = 14'd1536;
    pix_ready = 1'b1;
    tick();
    repeat (70000) tick();
    check("ur_sat", underrun_cnt, 16'hFFFF);

    // Reset asserted mid-stream clears outputs immediately.
    for (int i = 0; i < 9; i++) fifo_q.push_back(8'($urandom));
    pix_ready = 1'b0;
    repeat (8) tick();
    check("pre_reset_pv", pix_valid, 1);
    rd_rst_n = 1'b0;
    #1;
    check_zero("midreset");
    do_reset();
    fifo_q = '{8'hC0, 8'hFF, 8'hEE};
    fifo_rd_water_level = 14'd1536;
    pix_ready = 1'b1;
    repeat (10) tick();
    check("post_reset_pix", (got_q.size() > 0) ? got_q[0] : 24'd0, 24'hC0FFEE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rgb_unpack.md
FIFO_RGB_UNPACK -- requirements
Module: fifo_rgb_unpack

Interface
REQ-001 The block SHALL have parameter FILL_THRESH, default 1536: minimum FIFO read water level before pixel output starts.
REQ-002 The block SHALL have parameter WL_WIDTH, default 14: width of the FIFO read water-level input.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port rd_clk, input, 1 bit: the single clock (FIFO read-side clock).
REQ-005 The block SHALL have port rd_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port fifo_rd_en, output, 1 bit: FIFO read request.
REQ-007 The block SHALL have port fifo_rd_data, input, 8 bits: FIFO read byte, valid exactly 1 cycle after an accepted read.
REQ-008 The block SHALL have port fifo_rd_empty, input, 1 bit: FIFO empty flag.
REQ-009 The block SHALL have port fifo_rd_water_level, input, WL_WIDTH bits: FIFO read water level.
REQ-010 The block SHALL have port frame_start, input, 1 bit: one-cycle resynchronisation pulse from video timing.
REQ-011 The block SHALL have port pix_ready, input, 1 bit: the downstream consumer accepts a pixel.
REQ-012 The block SHALL have port pix_valid, output, 1 bit: pix_data holds a pixel.
REQ-013 The block SHALL have port pix_data, output, 24 bits: pixel {R[23:16], G[15:8], B[7:0]}.
REQ-014 The block SHALL have port underrun, output, 1 bit: sticky underrun flag.
REQ-015 The block SHALL have port underrun_cnt, output, 16 bits: saturating underrun count.

Function
REQ-016 The block SHALL have states WAIT_FILL and RUN.
REQ-017 In WAIT_FILL, fifo_rd_en SHALL be 0; the block SHALL go to RUN on the cycle after fifo_rd_water_level >= FILL_THRESH.
REQ-018 In RUN, fifo_rd_en SHALL be !fifo_rd_empty && ((held + inflight < 2) || !pix_valid || pix_ready); held = assembled bytes (0..2), inflight = read issued the previous cycle (0/1).
REQ-019 The block SHALL never assert fifo_rd_en while fifo_rd_empty=1, and no returned byte SHALL ever be dropped or overwritten outside frame_start.
REQ-020 Returned bytes SHALL fill in order R, G, B; on the third byte the pixel SHALL load into pix_data with pix_valid=1 on the next cycle.
REQ-021 With a continuously non-empty FIFO and pix_ready=1, latency from first fifo_rd_en to pix_valid SHALL be 4 cycles, and throughput SHALL be 1 pixel per 3 cycles.
REQ-022 pix_valid/pix_data SHALL hold stable until a cycle with pix_valid && pix_ready; the transfer occurs in that cycle.
REQ-023 In RUN, a cycle with pix_ready=1 and pix_valid=0 SHALL set underrun and increment underrun_cnt; underrun_cnt SHALL saturate at 0xFFFF; WAIT_FILL cycles SHALL not count.
REQ-024 frame_start SHALL, on the next cycle: clear held bytes, discard any in-flight byte, clear pix_valid, and enter WAIT_FILL, regardless of state.
REQ-025 frame_start coincident with pix_valid && pix_ready SHALL complete that transfer, then clear as in REQ-024.
REQ-026 frame_start coincident with a third-byte arrival SHALL discard that pixel.
REQ-027 underrun and underrun_cnt SHALL be cleared only by reset, not by frame_start.
REQ-028 The water-level comparison SHALL be unsigned at WL_WIDTH bits.

Reset
REQ-029 While rd_rst_n=0, the outputs SHALL be: fifo_rd_en=0, pix_valid=0, pix_data=0, underrun=0, underrun_cnt=0; state SHALL be WAIT_FILL, held=0, inflight=0.
REQ-030 Reset asserted mid-pixel SHALL abandon all partial data; after release the block SHALL behave as from power-up.

Structure
REQ-031 Package fifo_rgb_pkg SHALL hold the state enum (WAIT_FILL, RUN), the byte-lane constants (R=2, G=1, B=0), and UNDERRUN_MAX=16'hFFFF.
REQ-032 The block SHALL be a single module with no sub-module; the FIFO instance lives in the parent.

Verification
REQ-033 Scenario: water level stepping 0->1535->1536 -> fifo_rd_en stays 0 until the cycle after the level reaches 1536.
REQ-034 Scenario: bytes 0x11,0x22,0x33,0x44,0x55,0x66 with pix_ready=1 -> pixels 0x112233 then 0x445566, with first pix_valid 4 cycles after the first fifo_rd_en.
REQ-035 Scenario: pix_ready=0 for 20 cycles in RUN -> pix_data held stable, at most 2 bytes held plus 1 pixel, no byte lost; all pixels appear in order after release.
REQ-036 Scenario: FIFO empties after 1 byte in RUN with pix_ready=1 for 10 cycles -> underrun=1 and underrun_cnt=10; fifo_rd_en is never high while empty.
REQ-037 Scenario: frame_start after 2 bytes of a pixel -> pix_valid=0 and state WAIT_FILL; after refill, the next pixel is built from 3 new bytes.
REQ-038 Scenario: 70000 forced underrun cycles -> underrun_cnt=0xFFFF; rd_rst_n low mid-stream -> all outputs 0 immediately.
